// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 timing defaults, colour widths and decoder state encoding.
package vga_timing_pkg;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_TOTAL = 800;
  localparam int VGA_H_SYNC = 96;
  localparam int VGA_H_OFFS = 144;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_TOTAL = 525;
  localparam int VGA_V_OFFS = 35;
  localparam int VGA_LOCK_FRAMES = 2;
  localparam int R_W = 3;
  localparam int G_W = 3;
  localparam int B_W = 2;
  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} sync_state_t;
endpackage

// File: rtl/sync_edge_det.sv
// sync_edge_det: strobe-qualified sampler of an idle-high sync line with fall/rise pulses.
module sync_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic stb,
  input  logic d,
  output logic fall,
  output logic rise
);
  logic q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= 1'b1;
    else if (stb) q <= d;
  assign fall = stb && q && !d;
  assign rise = stb && !q && d;
endmodule

// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: validates VGA sync timing, locks, and recovers pixel coordinates and colour.
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int H_SYNC = VGA_H_SYNC,
  parameter int H_OFFS = VGA_H_OFFS,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int V_OFFS = VGA_V_OFFS,
  parameter int LOCK_FRAMES = VGA_LOCK_FRAMES
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           pix_stb,
  input  logic           vga_hs,
  input  logic           vga_vs,
  input  logic [R_W-1:0] vga_r,
  input  logic [G_W-1:0] vga_g,
  input  logic [B_W-1:0] vga_b,
  output logic [9:0]     pix_x,
  output logic [8:0]     pix_y,
  output logic [R_W-1:0] pix_r,
  output logic [G_W-1:0] pix_g,
  output logic [B_W-1:0] pix_b,
  output logic           pix_valid,
  output logic           frame_start,
  output logic           locked,
  output logic           sync_err,
  output logic [7:0]     frame_cnt
);
  sync_state_t st, st_n;
  logic [3:0] good, good_n;
  logic [7:0] fc_n;
  logic [9:0] hcnt, vcnt, hcnt_n, vcnt_n;
  logic skip, skip_n, fs_n;
  logic hs_f, hs_r, vs_f, vs_rise_unused;
  logic t_out, w_err, l_err, f_err, err, in_win, pv;
  sync_edge_det u_hs (.clk(clk), .rst_n(rst_n), .stb(pix_stb), .d(vga_hs), .fall(hs_f), .rise(hs_r));
  sync_edge_det u_vs (.clk(clk), .rst_n(rst_n), .stb(pix_stb), .d(vga_vs), .fall(vs_f), .rise(vs_rise_unused));
  // A coincident hsync fall is counted into the frame before vsync reloads vcnt.
  always_comb begin
    hcnt_n = hs_f ? '0 : &hcnt ? hcnt : hcnt + 10'd1;
    vcnt_n = vs_f ? '0 : (hs_f && !(&vcnt)) ? vcnt + 10'd1 : vcnt;
    t_out = pix_stb && !hs_f && hcnt_n == 10'(H_TOTAL);
    w_err = hs_r && hcnt_n != 10'(H_SYNC);
    l_err = hs_f && !skip && {1'b0, hcnt} + 11'd1 != 11'(H_TOTAL);
    f_err = vs_f && {1'b0, vcnt} + {10'd0, hs_f} != 11'(V_TOTAL);
    err = st != SEARCH && (t_out || w_err || l_err || f_err);
    in_win = hcnt_n >= 10'(H_OFFS) && hcnt_n < 10'(H_OFFS + H_ACTIVE) &&
             vcnt_n >= 10'(V_OFFS) && vcnt_n < 10'(V_OFFS + V_ACTIVE);
    pv = pix_stb && st == LOCKED && in_win;
  end
  // The first line after entering CHECK may be partial, so its length is not judged.
  always_comb begin
    st_n = st;
    good_n = good;
    skip_n = skip && !(hs_f && st != SEARCH);
    fs_n = 1'b0;
    fc_n = frame_cnt;
    if (err) begin
      st_n = SEARCH;
      good_n = '0;
    end else if (vs_f)
      case (st)
        SEARCH: begin
          st_n = CHECK;
          good_n = '0;
          skip_n = 1'b1;
        end
        CHECK: begin
          good_n = good + 4'd1;
          st_n = good + 4'd1 == 4'(LOCK_FRAMES) ? LOCKED : CHECK;
        end
        LOCKED: begin
          fs_n = 1'b1;
          fc_n = frame_cnt + 8'd1;
        end
        default: st_n = SEARCH;
      endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      st <= SEARCH;
      good <= '0;
      skip <= 1'b0;
      hcnt <= '0;
      vcnt <= '0;
      frame_cnt <= '0;
      pix_valid <= 1'b0;
      frame_start <= 1'b0;
      sync_err <= 1'b0;
      locked <= 1'b0;
      pix_x <= '0;
      pix_y <= '0;
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
    end else begin
      st <= st_n;
      good <= good_n;
      skip <= skip_n;
      frame_cnt <= fc_n;
      pix_valid <= pv;
      frame_start <= fs_n;
      sync_err <= err;
      locked <= st_n == LOCKED;
      if (pix_stb) begin
        hcnt <= hcnt_n;
        vcnt <= vcnt_n;
      end
      if (pv) begin
        pix_x <= hcnt_n - 10'(H_OFFS);
        pix_y <= 9'(vcnt_n - 10'(V_OFFS));
        pix_r <= vga_r;
        pix_g <= vga_g;
        pix_b <= vga_b;
      end
    end
endmodule
